alu_dispatch: RTL and testbench

Issue stage directly upstream of the ALU. It buffers decoded instructions, reads operands from an internal register file or an immediate, and drives registered ctrl/A/B into the combinational ALU. It captures the ALU result and flags into an output register with a valid/ready handshake, and writes the result back to the register file. It is the first sequential wrapper around the ALU in the shader datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_dispatch_fifo.sv | 58 +++++
 rtl/alu_dispatch.sv | 160 ++++++++++++++++
 tb/tb_alu_dispatch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Package shared by the ALU issue stage.
// Opcode encodings, flag bit positions inside the 5-bit ALU flag vector,
// and the datapath widths.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int FLAGS_W = 5;
  localparam int OP_W    = 4;

  // ALU opcodes; 10..15 are unused and make the ALU return 0.
  localparam logic [OP_W-1:0] ADD  = 4'd0;
  localparam logic [OP_W-1:0] SUB  = 4'd1;
  localparam logic [OP_W-1:0] SL   = 4'd2;
  localparam logic [OP_W-1:0] SR   = 4'd3;
  localparam logic [OP_W-1:0] AND  = 4'd4;
  localparam logic [OP_W-1:0] OR   = 4'd5;
  localparam logic [OP_W-1:0] XOR  = 4'd6;
  localparam logic [OP_W-1:0] NAND = 4'd7;
  localparam logic [OP_W-1:0] NOT  = 4'd8;
  localparam logic [OP_W-1:0] NOR  = 4'd9;

  // Bit positions in the flag vector {LF,GF,EF,NF,ZF}.
  localparam int ZF = 0;
  localparam int NF = 1;
  localparam int EF = 2;
  localparam int GF = 3;
  localparam int LF = 4;

endpackage

// File: rtl/alu_dispatch_fifo.sv
// Synchronous instruction FIFO for the ALU issue stage.
// Read data is the current head (not registered), so a pushed entry can be
// popped on the very next edge.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write strobe and entry (ignored when full unless popping)
//   pop, dout       read strobe and current head entry
//   empty, full     occupancy status
module alu_dispatch_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: storage is cleared too so every register in the block powers up
      // at 0; drop this loop if the array must map onto a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the values from before this edge.
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// ALU issue stage: instruction FIFO -> issue register (drives the ALU) ->
// result register with valid/ready, plus a register file written back from
// the ALU result. r0 reads as zero and writes to it are dropped.
// Configuration macro: ALU_DISPATCH_BYPASS_EN
//   defined   : the ALU result is forwarded to a dependent head instruction,
//               so dependent ops issue every cycle.
//   undefined : a dependent head waits one bubble and reads the register
//               file after the producer's write.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                instruction handshake (in_ready = FIFO not full)
//   in_op/rd/rs1/rs2/imm/use_imm     decoded instruction
//   alu_ctrl/alu_a/alu_b             registered ALU inputs
//   alu_res/alu_flags                combinational ALU outputs
//   out_valid/out_ready              result handshake
//   out_rd/out_res/out_flags         held result
//   busy                             any instruction buffered or in flight
module alu_dispatch
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int NREGS = 16,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [RA_W-1:0]    in_rd,
  input  logic [RA_W-1:0]    in_rs1,
  input  logic [RA_W-1:0]    in_rs2,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_use_imm,
  output logic [OP_W-1:0]    alu_ctrl,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_res,
  input  logic [FLAGS_W-1:0] alu_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RA_W-1:0]    out_rd,
  output logic [DATA_W-1:0]  out_res,
  output logic [FLAGS_W-1:0] out_flags,
  output logic               busy
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
  } instr_t;

`ifdef ALU_DISPATCH_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  instr_t            fifo_din;
  instr_t            head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              i_valid;
  logic [RA_W-1:0]   i_rd;
  logic [DATA_W-1:0] rf [NREGS];
  logic              r_load;
  logic              i_free;
  logic              wr_en;
  logic              hazard;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign fifo_din = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      imm: in_imm, use_imm: in_use_imm};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  alu_dispatch_fifo #(.DEPTH(DEPTH), .W($bits(instr_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Stage R accepts when empty or draining; stage I may load when empty or
  // when its content moves into stage R on this edge.
  assign r_load = !out_valid || out_ready;
  assign i_free = !i_valid || r_load;
  // Write-back coincides with stage R capturing the ALU result.
  assign wr_en  = i_valid && r_load && (i_rd != '0);

  // Without forwarding, a head that reads the issuing rd waits one cycle so
  // its operand comes from the register file after the write-back.
  assign hazard = !BYP_EN && i_valid && (i_rd != '0) &&
                  ((head.rs1 == i_rd) || (!head.use_imm && (head.rs2 == i_rd)));
  assign pop    = !fifo_empty && i_free && !hazard;

  assign busy   = !fifo_empty || i_valid || out_valid;

  function automatic logic [DATA_W-1:0] read_reg(input logic [RA_W-1:0] src);
    if (src == '0)                            return '0;
    if (BYP_EN && i_valid && (i_rd == src))   return alu_res;
    if (wr_en && (i_rd == src))               return alu_res;
    return rf[src];
  endfunction

  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no
    // latch is inferred.
    op_a = read_reg(head.rs1);
    op_b = head.use_imm ? head.imm : read_reg(head.rs2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_valid   <= 1'b0;
      i_rd      <= '0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_res   <= '0;
      out_flags <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      // Stage I: a hazard leaves it invalid (bubble) while the ALU inputs hold.
      if (i_free) begin
        i_valid <= pop;
        if (pop) begin
          alu_ctrl <= head.op;
          alu_a    <= op_a;
          alu_b    <= op_b;
          i_rd     <= head.rd;
        end
      end
      // Stage R.
      if (r_load) begin
        out_valid <= i_valid;
        if (i_valid) begin
          out_res   <= alu_res;
          out_flags <= alu_flags;
          out_rd    <= i_rd;
        end
      end
      if (wr_en) rf[i_rd] <= alu_res;
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a behavioural ALU closes the loop, directed
// instructions push hand-computed results into a scoreboard, and a monitor
// pops and compares every accepted output.
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int RA_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [RA_W-1:0]   in_rd;
  logic [RA_W-1:0]   in_rs1;
  logic [RA_W-1:0]   in_rs2;
  logic [31:0]       in_imm;
  logic              in_use_imm;
  logic [3:0]        alu_ctrl;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [31:0]       alu_res;
  logic [4:0]        alu_flags;
  logic              out_valid;
  logic              out_ready;
  logic [RA_W-1:0]   out_rd;
  logic [31:0]       out_res;
  logic [4:0]        out_flags;
  logic              busy;

  typedef struct {
    logic [RA_W-1:0] rd;
    logic [31:0]     res;
    logic [4:0]      flags;
  } exp_t;

  exp_t sb[$];
  time  arr_q[$];
  int   n_out  = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef ALU_DISPATCH_BYPASS_EN
  localparam int DEP_GAP = 10;
`else
  localparam int DEP_GAP = 20;
`endif

  always #5 clk = ~clk;

  alu_dispatch #(.DEPTH(4), .NREGS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_res    (alu_res),
    .alu_flags  (alu_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_res    (out_res),
    .out_flags  (out_flags),
    .busy       (busy)
  );

  // Behavioural ALU (the environment the dispatch stage drives).
  always_comb begin
    case (alu_ctrl)
      ADD:     alu_res = alu_a + alu_b;
      SUB:     alu_res = alu_a - alu_b;
      SL:      alu_res = alu_a << alu_b[4:0];
      SR:      alu_res = alu_a >> alu_b[4:0];
      AND:     alu_res = alu_a & alu_b;
      OR:      alu_res = alu_a | alu_b;
      XOR:     alu_res = alu_a ^ alu_b;
      NAND:    alu_res = ~(alu_a & alu_b);
      NOT:     alu_res = ~alu_a;
      NOR:     alu_res = ~(alu_a | alu_b);
      default: alu_res = 32'd0;
    endcase
    alu_flags     = '0;
    alu_flags[ZF] = (alu_res == 32'd0);
    alu_flags[NF] = alu_res[31];
    alu_flags[EF] = (alu_a == alu_b);
    alu_flags[GF] = (alu_a > alu_b);
    alu_flags[LF] = (alu_a < alu_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output is compared against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      arr_q.push_back($time);
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_res), 32'hdead_beef);
      end else begin
        e = sb.pop_front();
        check("out_rd", 32'(out_rd), 32'(e.rd));
        check("out_res", out_res, e.res);
        check("out_flags", 32'(out_flags), 32'(e.flags));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [RA_W-1:0] rd,
                      input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                      input logic [31:0] imm, input logic use_imm,
                      input logic [31:0] eres, input logic [4:0] eflags,
                      output time t_acc);
    int w;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_use_imm = use_imm; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      t_acc = 0;
    end else begin
      @(posedge clk);
      t_acc = $time;
      sb.push_back('{rd: rd, res: eres, flags: eflags});
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_remaining", 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    time t0, t1, t2, td;
    int  n0;
    in_valid = 0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_use_imm = 0; out_ready = 1'b1;
    rst = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD r1 = r0 + 5, latency two cycles, then read r1 back into r15.
    arr_q.delete();
    send(ADD, 4'd1, 4'd0, 4'd0, 32'd5, 1'b1, 32'd5, 5'b10000, t0);
    drain();
    check("lat_add", 32'((arr_q.size() > 0) ? arr_q[0] - t0 : 0), 32'd25);
    send(ADD, 4'd15, 4'd1, 4'd0, 32'd0, 1'b1, 32'd5, 5'b01000, td);
    drain();

    // Dependent chain: r1=7; r2=r1-7; r3=r1+r2 (register operand).
    arr_q.delete();
    send(ADD, 4'd1, 4'd0, 4'd0, 32'd7, 1'b1, 32'd7, 5'b10000, t0);
    send(SUB, 4'd2, 4'd1, 4'd0, 32'd7, 1'b1, 32'd0, 5'b00101, t1);
    send(ADD, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0, 32'd7, 5'b01000, t2);
    check("b2b_accept", 32'(t1 - t0), 32'd10);
    drain();
    check("dep_gap1", 32'((arr_q.size() > 1) ? arr_q[1] - arr_q[0] : 0), 32'(DEP_GAP));
    check("dep_gap2", 32'((arr_q.size() > 2) ? arr_q[2] - arr_q[1] : 0), 32'(DEP_GAP));

    // Backpressure: 6 instructions fill FIFO + stage I + stage R.
    @(negedge clk);
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 6; i++)
      send(ADD, 4'(3 + i), 4'd0, 4'd0, 32'(10 + i), 1'b1, 32'(10 + i), 5'b10000, td);
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_res", out_res, 32'd10);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_output", 32'(n_out - n0), 32'd0);
    out_ready = 1'b1;
    drain();
    repeat (5) @(negedge clk);
    check("stall_count", 32'(n_out - n0), 32'd6);

    // r0 writes are dropped.
    send(ADD, 4'd0, 4'd0, 4'd0, 32'd9, 1'b1, 32'd9, 5'b10000, td);
    send(ADD, 4'd15, 4'd0, 4'd0, 32'd1, 1'b1, 32'd1, 5'b10000, td);
    send(OR, 4'd14, 4'd0, 4'd0, 32'd0, 1'b0, 32'd0, 5'b00101, td);
    drain();

    // Unused opcode 12: A=3, B=4 -> 0, still written to r6.
    send(ADD, 4'd5, 4'd0, 4'd0, 32'd3, 1'b1, 32'd3, 5'b10000, td);
    send(4'd12, 4'd6, 4'd5, 4'd0, 32'd4, 1'b1, 32'd0, 5'b10001, td);
    send(ADD, 4'd15, 4'd6, 4'd0, 32'd0, 1'b1, 32'd0, 5'b00101, td);
    drain();

    // Asynchronous reset with instructions in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(ADD, 4'd1, 4'd0, 4'd0, 32'd1, 1'b1, 32'd1, 5'b10000, td);
    send(ADD, 4'd2, 4'd0, 4'd0, 32'd2, 1'b1, 32'd2, 5'b10000, td);
    send(ADD, 4'd3, 4'd0, 4'd0, 32'd3, 1'b1, 32'd3, 5'b10000, td);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(ADD, 4'd15, 4'd1, 4'd0, 32'd0, 1'b1, 32'd0, 5'b00101, td);
    send(ADD, 4'd14, 4'd3, 4'd2, 32'd0, 1'b0, 32'd0, 5'b00101, td);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
